// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// instruction field widths, kept here so the core can reuse them.
package instr_loader_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 12;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,  // waiting for byte 0 (opcode + low operand nibble)
    ST_HI   = 2'd1,  // waiting for byte 1 (high operand byte)
    ST_FULL = 2'd2   // complete instruction held for the core
  } state_t;

endpackage

// File: rtl/instr_loader_btn_debounce.sv
// btn_debounce: two-flop synchronizer plus counter debouncer for a push
// button. Emits a one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, count consecutive disagreeing samples, toggle the debounced level.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
        press   <= ~level_q;  // only rising debounced edges are events
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles a two-byte instruction from DIP switches, one byte
// per debounced button press, and offers it to the core with valid/ready.
// Optional feature: define INSTR_LOADER_DROPCNT_EN to add a saturating
// 4-bit drop_cnt output counting presses discarded while an instruction is held.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_raw,
  input  logic [7:0]           sw_in,
  input  logic                 instr_ready,
  output logic                 instr_valid,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] instr,
  output logic                 pending_hi,
  output logic                 dropped
`ifdef INSTR_LOADER_DROPCNT_EN
  ,
  output logic [3:0]           drop_cnt
`endif
);

  state_t state_q, state_d;
  logic   press;
  logic   drop_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .press  (press)
  );

  assign instr_valid = (state_q == ST_FULL);
  assign pending_hi  = (state_q == ST_HI);
  assign drop_evt    = press && (state_q == ST_FULL);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_LO;
    else        state_q <= state_d;
  end

  // Next-state logic: presses advance LO->HI->FULL, a handshake returns to LO.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_LO:   if (press)       state_d = ST_HI;
      ST_HI:   if (press)       state_d = ST_FULL;
      ST_FULL: if (instr_ready) state_d = ST_LO;
      default:                  state_d = ST_LO;
    endcase
  end

  // Capture switch bytes into the instruction fields; hold them otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode  <= '0;
      instr   <= '0;
      dropped <= 1'b0;
    end else begin
      if (press && state_q == ST_LO) begin
        opcode     <= sw_in[3:0];
        instr[3:0] <= sw_in[7:4];
      end
      if (press && state_q == ST_HI) begin
        instr[11:4] <= sw_in;
      end
      if (drop_evt) begin
        dropped <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_DROPCNT_EN
  // Count discarded presses, saturating at 15.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_evt && drop_cnt != 4'hF) begin
      drop_cnt <= drop_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader with DEBOUNCE_CYCLES=4. A behavioural
// model tracks captured bytes, the held instruction and the drop flag/count.
module tb_instr_loader;

  localparam int DB = 4;

  logic        clk;
  logic        rst_n;
  logic        btn_raw;
  logic [7:0]  sw_in;
  logic        instr_ready;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        pending_hi;
  logic        dropped;
`ifdef INSTR_LOADER_DROPCNT_EN
  logic [3:0]  drop_cnt;
`endif

  instr_loader #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .sw_in      (sw_in),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .instr      (instr),
    .pending_hi (pending_hi),
    .dropped    (dropped)
`ifdef INSTR_LOADER_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: number of bytes collected, held fields, drop tracking.
  int          m_bytes;
  logic [3:0]  m_op;
  logic [11:0] m_instr;
  logic        m_drop;
  int          m_dcnt;

  task automatic model_reset();
    m_bytes = 0;
    m_op    = '0;
    m_instr = '0;
    m_drop  = 1'b0;
    m_dcnt  = 0;
  endtask

  task automatic model_press(input logic [7:0] sw, input logic rdy);
    if (m_bytes == 0) begin
      m_op          = sw[3:0];
      m_instr[3:0]  = sw[7:4];
      m_bytes       = 1;
    end else if (m_bytes == 1) begin
      m_instr[11:4] = sw;
      m_bytes       = 2;
    end else begin
      m_drop = 1'b1;
      if (m_dcnt < 15) m_dcnt++;
      if (rdy) m_bytes = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/valid"},   32'(instr_valid), 32'(m_bytes == 2));
    check({tag, "/pending"}, 32'(pending_hi),  32'(m_bytes == 1));
    check({tag, "/opcode"},  32'(opcode),      32'(m_op));
    check({tag, "/instr"},   32'(instr),       32'(m_instr));
    check({tag, "/dropped"}, 32'(dropped),     32'(m_drop));
`ifdef INSTR_LOADER_DROPCNT_EN
    check({tag, "/dcnt"},    32'(drop_cnt),    32'(m_dcnt));
`endif
  endtask

  // Called at a falling edge. btn_raw rises here, so the next rising edge is
  // edge N; the capture is expected on edge N+2+DB. Outputs are checked just
  // before and just after that edge. rdy is driven only across the capture edge.
  task automatic press_byte(input string tag, input logic [7:0] sw,
                            input logic rdy, input logic bounce);
    sw_in = sw;
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        btn_raw = ~i[0];
        @(negedge clk);
      end
    end
    btn_raw = 1'b1;
    repeat (DB + 2) @(negedge clk);
    check_all({tag, "/pre"});
    instr_ready = rdy;
    @(negedge clk);
    instr_ready = 1'b0;
    model_press(sw, rdy);
    check_all({tag, "/post"});
    repeat (4) @(negedge clk);
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
    check_all({tag, "/rel"});
  endtask

  task automatic handshake(input string tag, input logic rdy);
    instr_ready = rdy;
    @(negedge clk);
    instr_ready = 1'b0;
    if (rdy && m_bytes == 2) m_bytes = 0;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r_sw;
    logic       r_rdy;
    int         r_op;

    rst_n       = 1'b0;
    btn_raw     = 1'b0;
    sw_in       = 8'h00;
    instr_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Pulse shorter than the debounce window: no event.
    sw_in   = 8'hFF;
    btn_raw = 1'b1;
    repeat (DB - 1) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_all("short_pulse");

    // Bouncing lead-in, then two clean bytes forming 0x3 / 0x5CA.
    press_byte("bounce_a3", 8'hA3, 1'b0, 1'b1);
    press_byte("byte_5c",   8'h5C, 1'b0, 1'b0);
    check("op_const",    32'(opcode),      32'h3);
    check("instr_const", 32'(instr),       32'h5CA);
    check("valid_const", 32'(instr_valid), 32'h1);

    // Press and handshake on the same edge: back to LO, press discarded.
    press_byte("drop_hs", 8'h77, 1'b1, 1'b0);
    check("hs_instr_kept", 32'(instr), 32'h5CA);

    // Ready while not FULL is ignored.
    handshake("ready_in_lo", 1'b1);

    // Refill, then hammer with presses while held to saturate the counter.
    press_byte("fill_lo", 8'h21, 1'b0, 1'b0);
    press_byte("fill_hi", 8'hE4, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      press_byte("drop_sat", 8'(i * 37), 1'b0, 1'b0);
    end
    handshake("hs_after_drops", 1'b1);

    // Reset while in HI abandons the partial instruction.
    press_byte("pre_rst_lo", 8'h9D, 1'b0, 1'b0);
    pulse_reset();
    press_byte("fresh_lo", 8'h64, 1'b0, 1'b0);
    press_byte("fresh_hi", 8'hB2, 1'b0, 1'b0);
    handshake("fresh_hs", 1'b1);

    // Reset while mid-debounce: no event after release.
    btn_raw = 1'b1;
    sw_in   = 8'h11;
    repeat (3) @(negedge clk);
    btn_raw = 1'b0;
    pulse_reset();
    repeat (12) @(negedge clk);
    check_all("rst_mid_db");

    // Button held high through reset release: exactly one press.
    sw_in   = 8'hC7;
    btn_raw = 1'b1;
    pulse_reset();
    repeat (12) @(negedge clk);
    model_press(8'hC7, 1'b0);
    check_all("held_thru_rst");
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_all("held_release");

    // Randomized presses and handshakes against the model.
    for (int i = 0; i < 40; i++) begin
      r_op  = int'($urandom_range(0, 2));
      r_sw  = 8'($urandom);
      r_rdy = 1'($urandom_range(0, 1));
      if (r_op < 2) press_byte("rnd_press", r_sw, r_rdy, 1'b0);
      else          handshake("rnd_hs", r_rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
